pe_row_feeder: RTL and testbench
================================

// Module: pe_row_feeder
// PURPOSE
//  Upstream operand feeder for one pe. Takes separate valid/ready streams of
//  filter and ifmap words and loads one row (ROW_LEN filter/ifmap pairs) into
//  the pe register files. Issues single-cycle filter_enable/ifmap_enable pulses,
//  alternating filter then ifmap, and stalls while the pe deasserts ready.
// PARAMETERS
//  BITWIDTH  16  width of filter/ifmap words (signed, two's complement)
//  ROW_LEN   3   filter/ifmap pairs loaded per start (>=1)
// PORTS
//  clk              in   1         clock, all logic on rising edge
//  rst              in   1         synchronous reset, active-high
//  start            in   1         begin loading one row; sampled in IDLE only
//  filter_in_valid  in   1         filter word available
//  filter_in_ready  out  1         feeder accepts filter word this cycle
//  filter_in        in   BITWIDTH  filter word (signed)
//  ifmap_in_valid   in   1         ifmap word available
//  ifmap_in_ready   out  1         feeder accepts ifmap word this cycle
//  ifmap_in         in   BITWIDTH  ifmap word (signed)
//  pe_ready         in   1         pe ready output; 1 = may load operands
//  filter_enable    out  1         to pe filter_enable, 1-cycle pulse per word
//  filter           out  BITWIDTH  to pe filter; holds last loaded word
//  ifmap_enable     out  1         to pe ifmap_enable, 1-cycle pulse per word
//  ifmap            out  BITWIDTH  to pe ifmap; holds last loaded word
//  busy             out  1         1 in any state except IDLE
//  done             out  1         1-cycle pulse: row fully loaded
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, pair count=0; all outputs 0.
//  States: IDLE, LOAD_FILT, LOAD_IFMAP, DONE.
//   IDLE: start=1 -> LOAD_FILT, count=0. Else stay.
//   LOAD_FILT: filter_in_ready = pe_ready (combinational). On
//    filter_in_valid & filter_in_ready -> LOAD_IFMAP.
//   LOAD_IFMAP: ifmap_in_ready = pe_ready. On accept: count+1; if new
//    count == ROW_LEN -> DONE, else -> LOAD_FILT.
//   DONE: done=1 for exactly one cycle -> IDLE unconditionally.
//  *_in_ready is 0 in every state other than its own LOAD state.
//  Latency: word accepted at edge N -> filter/ifmap register updated and
//   matching enable=1 for cycle N..N+1 only (registered, 1 cycle).
//   Enable is 0 in any cycle without a preceding accept.
//  Data words pass through unmodified (no sign change, no truncation).
//  Back-to-back: with valid and pe_ready held high, enables alternate
//   F,I,F,I... on consecutive cycles; a row takes 2*ROW_LEN cycles of
//   LOAD states; final ifmap_enable coincides with the DONE cycle.
//  Stall: pe_ready=0 or valid=0 holds state and count; no enable pulses;
//   filter/ifmap outputs hold their last value.
//  start while busy (incl. DONE cycle) is ignored; no queuing.
//  rst mid-row: abort immediately, partial count discarded, no done pulse;
//   next start loads from pair 0.
//  Count width $clog2(ROW_LEN+1); never wraps (cleared on IDLE->LOAD_FILT).
// TESTING
//  1 Reset: hold rst 2 cycles with valids=1 -> all outputs 0, both in_ready 0.
//  2 Row load, ROW_LEN=3, pe_ready=1, filter 1,2,3 / ifmap 5,6,7 always
//    valid -> enables F1,I5,F2,I6,F3,I7 on 6 consecutive cycles, done=1
//    with I7, busy drops next cycle.
//  3 pe_ready=0 for 2 cycles after F2 accepted -> ifmap_in_ready=0, no
//    enables for 2 cycles, then I6,F3,I7; filter holds 2 during stall.
//  4 Signed pass-through: filter -32768, ifmap -1 -> pe filter=16'h8000,
//    ifmap=16'hFFFF on the enable cycles.
//  5 ifmap_in_valid gaps of 3 cycles per word -> state waits in LOAD_IFMAP,
//    exactly 3 ifmap_enable pulses, done once.
//  6 start pulsed during LOAD_IFMAP and DONE -> ignored; rst after F2 ->
//    IDLE, no done; new start loads filter 1 as first word.

Source files
------------

// File: rtl/pe_row_feeder.sv
// Loads one row of ROW_LEN filter/ifmap pairs into a pe, alternating
// filter then ifmap words, with single-cycle enable pulses per word.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start                            begin a row (sampled in IDLE only)
//   filter_in_valid/_ready/filter_in upstream filter word stream
//   ifmap_in_valid/_ready/ifmap_in   upstream ifmap word stream
//   pe_ready                         pe may accept operands
//   filter_enable/filter             pe filter load pulse and word
//   ifmap_enable/ifmap               pe ifmap load pulse and word
//   busy                             high in any state except IDLE
//   done                             one-cycle pulse when the row is loaded
module pe_row_feeder #(
    parameter int BITWIDTH = 16,
    parameter int ROW_LEN  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                filter_in_valid,
    output logic                filter_in_ready,
    input  logic [BITWIDTH-1:0] filter_in,
    input  logic                ifmap_in_valid,
    output logic                ifmap_in_ready,
    input  logic [BITWIDTH-1:0] ifmap_in,
    input  logic                pe_ready,
    output logic                filter_enable,
    output logic [BITWIDTH-1:0] filter,
    output logic                ifmap_enable,
    output logic [BITWIDTH-1:0] ifmap,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(ROW_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(ROW_LEN);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_FILT,
        LOAD_IFMAP,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nx;
    logic          filt_acc;
    logic          ifm_acc;

    always_comb begin
        state_nx        = state;
        count_nx        = count;
        filter_in_ready = 1'b0;
        ifmap_in_ready  = 1'b0;
        filt_acc        = 1'b0;
        ifm_acc         = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = LOAD_FILT;
                    count_nx = '0;
                end
            end
            LOAD_FILT: begin
                // Ready is withheld during reset so upstream never sees a
                // handshake that the reset would silently discard.
                filter_in_ready = pe_ready & ~rst;
                filt_acc        = filter_in_valid & filter_in_ready;
                if (filt_acc) begin
                    state_nx = LOAD_IFMAP;
                end
            end
            LOAD_IFMAP: begin
                ifmap_in_ready = pe_ready & ~rst;
                ifm_acc        = ifmap_in_valid & ifmap_in_ready;
                if (ifm_acc) begin
                    count_nx = count + ONE;
                    if (count_nx == LAST) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = LOAD_FILT;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            filter_enable <= 1'b0;
            ifmap_enable  <= 1'b0;
            filter        <= '0;
            ifmap         <= '0;
        end else begin
            state         <= state_nx;
            count         <= count_nx;
            filter_enable <= filt_acc;
            ifmap_enable  <= ifm_acc;
            if (filt_acc) begin
                filter <= filter_in;
            end
            if (ifm_acc) begin
                ifmap <= ifmap_in;
            end
        end
    end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Scoreboard bench for pe_row_feeder: a pair-count model predicts the
// enable/data stream and handshakes; a negedge monitor checks them.
module tb_pe_row_feeder;

    localparam int BW = 16;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          fv = 1'b0;
    logic          iv = 1'b0;
    logic [BW-1:0] fin = '0;
    logic [BW-1:0] iin = '0;
    logic          per = 1'b0;
    logic          filter_in_ready;
    logic          ifmap_in_ready;
    logic          filter_enable;
    logic          ifmap_enable;
    logic [BW-1:0] filter;
    logic [BW-1:0] ifmap;
    logic          busy;
    logic          done;

    pe_row_feeder #(.BITWIDTH(BW), .ROW_LEN(RL)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .filter_in_valid(fv),
        .filter_in_ready(filter_in_ready),
        .filter_in(fin),
        .ifmap_in_valid(iv),
        .ifmap_in_ready(ifmap_in_ready),
        .ifmap_in(iin),
        .pe_ready(per),
        .filter_enable(filter_enable),
        .filter(filter),
        .ifmap_enable(ifmap_enable),
        .ifmap(ifmap),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_f;
        logic [BW-1:0] val;
    } exp_t;

    exp_t          q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            mon_en = 0;

    // Model: row active flag, filter/ifmap words taken so far, DONE cycle.
    bit            m_active = 0;
    bit            m_done = 0;
    int            m_fc = 0;
    int            m_ic = 0;
    logic [BW-1:0] m_filt = '0;
    logic [BW-1:0] m_ifm = '0;

    logic [BW-1:0] fw[RL];
    logic [BW-1:0] iw[RL];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit was_act;
        bit was_done;
        was_act  = m_active;
        was_done = m_done;
        if (rst) begin
            m_active = 0;
            m_done   = 0;
            m_fc     = 0;
            m_ic     = 0;
            m_filt   = '0;
            m_ifm    = '0;
            q.delete();
            return;
        end
        m_done = 0;
        if (!was_act && !was_done) begin
            if (start) begin
                m_active = 1;
                m_fc     = 0;
                m_ic     = 0;
            end
        end else if (was_act) begin
            if (m_fc == m_ic) begin
                if (fv && per) begin
                    q.push_back('{1'b1, fin});
                    m_filt = fin;
                    m_fc++;
                end
            end else if (iv && per) begin
                q.push_back('{1'b0, iin});
                m_ifm = iin;
                m_ic++;
                if (m_ic == RL) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        mon_en = 1;
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("busy", busy, m_active || m_done);
            check("done", done, m_done);
            check("filter_in_ready", filter_in_ready,
                  !rst && m_active && m_fc == m_ic && per);
            check("ifmap_in_ready", ifmap_in_ready,
                  !rst && m_active && m_fc > m_ic && per);
            check("filter_hold", filter, m_filt);
            check("ifmap_hold", ifmap, m_ifm);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("filter_enable", filter_enable, e.is_f);
                check("ifmap_enable", ifmap_enable, !e.is_f);
                if (e.is_f) check("filter_word", filter, e.val);
                else check("ifmap_word", ifmap, e.val);
            end else begin
                check("filter_enable_quiet", filter_enable, 0);
                check("ifmap_enable_quiet", ifmap_enable, 0);
            end
        end
    end

    task automatic run_row(input int stall_f, input int stall_len,
                           input int gap, input bit hold_start,
                           input int abort_f);
        int left;
        int waitc;
        int n;
        int pic;
        left  = stall_len;
        waitc = 0;
        n     = 0;
        start = 1;
        fv    = 1;
        iv    = 1;
        per   = 1;
        rst   = 0;
        fin   = fw[0];
        iin   = iw[0];
        cyc();
        start = hold_start;
        pic   = m_ic;
        while ((m_active || m_done) && n < 200) begin
            if (m_ic != pic) begin
                waitc = 0;
                pic   = m_ic;
            end
            if (abort_f >= 0 && m_fc == abort_f && m_ic == abort_f - 1) begin
                rst = 1;
                cyc();
                rst = 0;
                break;
            end
            fin = fw[m_fc < RL ? m_fc : 0];
            iin = iw[m_ic < RL ? m_ic : 0];
            per = 1;
            if (stall_f >= 0 && m_fc == stall_f && m_ic == stall_f - 1
                && left > 0) begin
                per = 0;
                left--;
            end
            iv = (m_fc > m_ic) ? (waitc >= gap) : 1'b1;
            if (m_fc > m_ic) waitc++;
            cyc();
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL row_timeout: row still busy after %0d cycles", n);
        end
        start = 0;
        cyc();
    endtask

    initial begin
        // Reset held two cycles with both streams valid.
        rst = 1;
        fv  = 1;
        iv  = 1;
        cyc();
        cyc();
        rst = 0;
        fv  = 0;
        iv  = 0;
        cyc();

        // Plain row, back-to-back.
        fw = '{16'd1, 16'd2, 16'd3};
        iw = '{16'd5, 16'd6, 16'd7};
        run_row(-1, 0, 0, 0, -1);

        // pe stall after F2 for two cycles.
        run_row(2, 2, 0, 0, -1);

        // Signed extremes pass through untouched.
        fw = '{16'h8000, 16'h7FFF, 16'h8001};
        iw = '{16'hFFFF, 16'h0000, 16'h8000};
        run_row(-1, 0, 0, 0, -1);

        // Ifmap arrives with three-cycle gaps.
        fw = '{16'd1, 16'd2, 16'd3};
        iw = '{16'd5, 16'd6, 16'd7};
        run_row(-1, 0, 3, 0, -1);

        // Start held high through the row and DONE cycle.
        run_row(-1, 0, 0, 1, -1);

        // Reset after F2, then a fresh row from pair 0.
        run_row(-1, 0, 0, 0, 2);
        cyc();
        run_row(-1, 0, 0, 0, -1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 6) == 0;
            fv    = ($urandom % 10) < 7;
            iv    = ($urandom % 10) < 7;
            per   = ($urandom % 10) < 8;
            fin   = BW'($urandom);
            iin   = BW'($urandom);
            rst   = ($urandom % 300) == 0;
            cyc();
        end
        rst   = 0;
        start = 0;
        for (int i = 0; i < 10; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
